// File: rtl/uart_frame_parser.sv
// uart_frame_parser: delineates AA 55 LEN payload [checksum] frames from a UART byte stream.
// Define UART_FRAME_CHKSUM_EN to build the trailing checksum byte and its S_CHK state.
module uart_frame_parser #(
    parameter int MAX_LEN       = 32,
    parameter int TIMEOUT_TICKS = 480
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_16_i,
    input  logic [7:0] rxd_data_i,
    input  logic       rxd_flag_i,
    output logic [7:0] pay_data_o,
    output logic       pay_valid_o,
    output logic [7:0] pay_idx_o,
    output logic [7:0] frame_len_o,
    output logic       frame_ok_o,
    output logic       frame_err_o,
    output logic [1:0] err_code_o
);
`ifdef UART_FRAME_CHKSUM_EN
    typedef enum logic [2:0] {S_HDR0, S_HDR1, S_LEN, S_PAY, S_CHK} state_t;
    logic [7:0] sum_q, sum_d;
`else
    typedef enum logic [1:0] {S_HDR0, S_HDR1, S_LEN, S_PAY} state_t;
`endif
    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] tmo_q, tmo_d;
    logic [7:0]  pay_data_d, pay_idx_d, frame_len_d;
    logic        pay_valid_d, frame_ok_d, frame_err_d;
    logic [1:0]  err_code_d;
    logic        bad_len, last;

    assign bad_len = rxd_data_i == 8'd0 || rxd_data_i > 8'(MAX_LEN);
    assign last    = cnt_q == frame_len_o - 8'd1;

    // Next-state and next-output logic; a byte always takes priority over the timeout tick.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tmo_d       = (rxd_flag_i || state_q == S_HDR0) ? 16'd0 : tmo_q + {15'd0, clk_16_i};
        pay_data_d  = pay_data_o;
        pay_valid_d = 1'b0;
        pay_idx_d   = pay_idx_o;
        frame_len_d = frame_len_o;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_code_d  = err_code_o;
`ifdef UART_FRAME_CHKSUM_EN
        sum_d       = sum_q;
`endif
        if (rxd_flag_i) begin
            case (state_q)
                S_HDR0: state_d = (rxd_data_i == 8'hAA) ? S_HDR1 : S_HDR0;
                S_HDR1: state_d = (rxd_data_i == 8'h55) ? S_LEN : (rxd_data_i == 8'hAA) ? S_HDR1 : S_HDR0;
                S_LEN: begin
                    frame_err_d = bad_len;
                    err_code_d  = bad_len ? 2'b01 : err_code_o;
                    frame_len_d = bad_len ? frame_len_o : rxd_data_i;
                    cnt_d       = 8'd0;
                    state_d     = bad_len ? S_HDR0 : S_PAY;
`ifdef UART_FRAME_CHKSUM_EN
                    sum_d       = rxd_data_i;
`endif
                end
                S_PAY: begin
                    pay_data_d  = rxd_data_i;
                    pay_valid_d = 1'b1;
                    pay_idx_d   = cnt_q;
                    cnt_d       = cnt_q + 8'd1;
`ifdef UART_FRAME_CHKSUM_EN
                    sum_d       = sum_q + rxd_data_i;
                    state_d     = last ? S_CHK : S_PAY;
`else
                    frame_ok_d  = last;
                    state_d     = last ? S_HDR0 : S_PAY;
`endif
                end
`ifdef UART_FRAME_CHKSUM_EN
                S_CHK: begin
                    frame_ok_d  = rxd_data_i == sum_q;
                    frame_err_d = rxd_data_i != sum_q;
                    err_code_d  = (rxd_data_i == sum_q) ? err_code_o : 2'b10;
                    state_d     = S_HDR0;
                end
`endif
                default: state_d = S_HDR0;
            endcase
        end else if (state_q != S_HDR0 && clk_16_i && tmo_q == 16'(TIMEOUT_TICKS - 1)) begin
            frame_err_d = 1'b1;
            err_code_d  = 2'b11;
            state_d     = S_HDR0;
            tmo_d       = 16'd0;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_HDR0;
            cnt_q       <= 8'd0;
            tmo_q       <= 16'd0;
            pay_data_o  <= 8'd0;
            pay_valid_o <= 1'b0;
            pay_idx_o   <= 8'd0;
            frame_len_o <= 8'd0;
            frame_ok_o  <= 1'b0;
            frame_err_o <= 1'b0;
            err_code_o  <= 2'b00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            pay_data_o  <= pay_data_d;
            pay_valid_o <= pay_valid_d;
            pay_idx_o   <= pay_idx_d;
            frame_len_o <= frame_len_d;
            frame_ok_o  <= frame_ok_d;
            frame_err_o <= frame_err_d;
            err_code_o  <= err_code_d;
        end
    end

`ifdef UART_FRAME_CHKSUM_EN
    // Running checksum of LEN plus payload bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sum_q <= 8'd0;
        else sum_q <= sum_d;
    end
`endif
endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser: frame-level expectation model and per-cycle compare for uart_frame_parser.
module tb_uart_frame_parser;
`ifdef UART_FRAME_CHKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    localparam int MAX_LEN = 32;
    localparam int N = 8192;

    logic       clk = 1'b0, rst_n = 1'b0, clk_16_i = 1'b0, rxd_flag_i = 1'b0;
    logic [7:0] rxd_data_i = 8'd0;
    logic [7:0] pay_data_o, pay_idx_o, frame_len_o;
    logic       pay_valid_o, frame_ok_o, frame_err_o;
    logic [1:0] err_code_o;

    uart_frame_parser #(.MAX_LEN(MAX_LEN), .TIMEOUT_TICKS(480)) dut (
        .clk(clk), .rst_n(rst_n), .clk_16_i(clk_16_i), .rxd_data_i(rxd_data_i),
        .rxd_flag_i(rxd_flag_i), .pay_data_o(pay_data_o), .pay_valid_o(pay_valid_o),
        .pay_idx_o(pay_idx_o), .frame_len_o(frame_len_o), .frame_ok_o(frame_ok_o),
        .frame_err_o(frame_err_o), .err_code_o(err_code_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected events indexed by the cycle in which the registered output shows them.
    bit         e_pv[N], e_ok[N], e_err[N], e_lu[N];
    logic [7:0] e_pd[N], e_pi[N], e_lv[N];
    logic [1:0] e_code[N];
    logic [1:0] m_code = 2'b00;
    logic [7:0] m_len = 8'd0;
    logic [7:0] pbuf[8];
    int n_pass = 0, n_chk = 0;
    int obs_ok = 0, obs_err = 0, obs_pv = 0;
    int o0, r0, p0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0h, want %0h", name, cyc, act, exp);
    endtask

    // Per-cycle comparison of every output against the expectation tables.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_code = 2'b00;
            m_len  = 8'd0;
            chk("reset_outputs", {2'b0, pay_valid_o, frame_ok_o, frame_err_o, err_code_o,
                frame_len_o, pay_data_o, pay_idx_o}, 32'd0);
        end else begin
            if (e_err[cyc]) m_code = e_code[cyc];
            if (e_lu[cyc]) m_len = e_lv[cyc];
            chk("pay_valid", pay_valid_o, e_pv[cyc]);
            if (e_pv[cyc]) begin
                chk("pay_data", pay_data_o, e_pd[cyc]);
                chk("pay_idx", pay_idx_o, e_pi[cyc]);
            end
            chk("frame_ok", frame_ok_o, e_ok[cyc]);
            chk("frame_err", frame_err_o, e_err[cyc]);
            chk("err_code", err_code_o, m_code);
            chk("frame_len", frame_len_o, m_len);
            obs_ok += int'(frame_ok_o);
            obs_err += int'(frame_err_o);
            obs_pv += int'(pay_valid_o);
        end
    end

    task automatic step(input logic f, input logic [7:0] d, input logic t);
        rxd_flag_i = f;
        rxd_data_i = d;
        clk_16_i   = t;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] sum8(input int len);
        int s = len;
        for (int i = 0; i < len; i++) s += pbuf[i];
        return 8'(s);
    endfunction

    task automatic hdr_len(input logic [7:0] len);
        step(1'b1, 8'hAA, 1'b0);
        step(1'b1, 8'h55, 1'b0);
        if (len == 8'd0 || int'(len) > MAX_LEN) begin
            e_err[cyc + 1]  = 1'b1;
            e_code[cyc + 1] = 2'b01;
        end else begin
            e_lu[cyc + 1] = 1'b1;
            e_lv[cyc + 1] = len;
        end
        step(1'b1, len, 1'b0);
    endtask

    task automatic pay_byte(input int i, input int len, input logic t);
        e_pv[cyc + 1] = 1'b1;
        e_pd[cyc + 1] = pbuf[i];
        e_pi[cyc + 1] = 8'(i);
        if (!CHK && i == len - 1) e_ok[cyc + 1] = 1'b1;
        step(1'b1, pbuf[i], t);
    endtask

    task automatic close(input int len, input logic [7:0] cs);
        if (CHK) begin
            if (cs == sum8(len)) e_ok[cyc + 1] = 1'b1;
            else begin
                e_err[cyc + 1]  = 1'b1;
                e_code[cyc + 1] = 2'b10;
            end
            step(1'b1, cs, 1'b0);
        end
    endtask

    task automatic frame(input logic [7:0] len, input logic [7:0] cs);
        hdr_len(len);
        if (len != 8'd0 && int'(len) <= MAX_LEN) begin
            for (int i = 0; i < int'(len); i++) pay_byte(i, int'(len), 1'b0);
            close(int'(len), cs);
        end
    endtask

    task automatic mark;
        o0 = obs_ok;
        r0 = obs_err;
        p0 = obs_pv;
    endtask

    initial begin
        repeat (3) step(1'b0, 8'h00, 1'b0);
        rst_n = 1'b1;
        step(1'b0, 8'h00, 1'b0);

        pbuf = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        chk("model_sum_good", sum8(3), 8'h69);
        mark();
        frame(8'd3, 8'h69);
        step(1'b0, 8'h00, 1'b0);
        chk("good_ok_count", obs_ok - o0, 1);
        chk("good_err_count", obs_err - r0, 0);
        chk("good_pay_count", obs_pv - p0, 3);
        chk("good_len", frame_len_o, 8'h03);

        pbuf = '{8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        chk("model_sum_bad", sum8(2), 8'h05);
        mark();
        frame(8'd2, 8'h00);
        step(1'b0, 8'h00, 1'b0);
        chk("badchk_err_count", obs_err - r0, CHK ? 1 : 0);
        chk("badchk_ok_count", obs_ok - o0, CHK ? 0 : 1);
        chk("badchk_code", err_code_o, CHK ? 2'b10 : 2'b00);

        mark();
        frame(8'h00, 8'h00);
        frame(8'h21, 8'h00);
        step(1'b0, 8'h00, 1'b0);
        chk("badlen_err_count", obs_err - r0, 2);
        chk("badlen_pay_count", obs_pv - p0, 0);
        chk("badlen_code", err_code_o, 2'b01);
        pbuf = '{8'h7E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        mark();
        frame(8'd1, 8'h7F);
        step(1'b0, 8'h00, 1'b0);
        chk("after_badlen_ok", obs_ok - o0, 1);

        pbuf = '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        mark();
        step(1'b1, 8'h12, 1'b0);
        step(1'b1, 8'hAA, 1'b0);
        frame(8'd1, 8'h5B);
        step(1'b0, 8'h00, 1'b0);
        chk("resync_ok", obs_ok - o0, 1);
        chk("resync_err", obs_err - r0, 0);
        chk("resync_pay", obs_pv - p0, 1);

        pbuf = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00};
        mark();
        hdr_len(8'd4);
        pay_byte(0, 4, 1'b0);
        for (int i = 1; i <= 480; i++) begin
            if (i == 480) begin
                e_err[cyc + 1]  = 1'b1;
                e_code[cyc + 1] = 2'b11;
            end
            step(1'b0, 8'h00, 1'b1);
            step(1'b0, 8'h00, 1'b0);
        end
        chk("timeout_err", obs_err - r0, 1);
        chk("timeout_code", err_code_o, 2'b11);

        mark();
        hdr_len(8'd4);
        pay_byte(0, 4, 1'b0);
        for (int i = 1; i < 480; i++) begin
            step(1'b0, 8'h00, 1'b1);
            step(1'b0, 8'h00, 1'b0);
        end
        pay_byte(1, 4, 1'b1);
        pay_byte(2, 4, 1'b0);
        pay_byte(3, 4, 1'b0);
        close(4, sum8(4));
        step(1'b0, 8'h00, 1'b0);
        chk("tick_vs_byte_err", obs_err - r0, 0);
        chk("tick_vs_byte_ok", obs_ok - o0, 1);

        pbuf = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        mark();
        hdr_len(8'd5);
        pay_byte(0, 5, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        rst_n = 1'b0;
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        rst_n = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        chk("reset_no_ok", obs_ok - o0, 0);
        chk("reset_no_err", obs_err - r0, 0);
        pbuf = '{8'hA0, 8'hB1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        chk("model_sum_wrap", sum8(2), 8'h53);
        mark();
        frame(8'd2, 8'h53);
        step(1'b0, 8'h00, 1'b0);
        chk("post_reset_ok", obs_ok - o0, 1);
        chk("post_reset_len", frame_len_o, 8'h02);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
